// File: rtl/div_unit_if.sv
// Handshake and data bundle between the ID/EX side of the core and the divide unit.
// The core drives the request, and the divide unit returns status and the result.
interface div_unit_if;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, func3, dividend, divisor, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, func3, dividend, divisor, flush,
        output busy, done, result
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit using radix-2 restoring division.
// Divide-by-zero and signed overflow skip the iteration loop and finish one cycle after start.
module div_unit (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int XLEN = 32;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            is_rem_q;
    logic            negate_q;
    logic [5:0]      count_q;
    logic [XLEN-1:0] div_mag_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] result_q;

    logic            op_signed;
    logic            op_rem;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN-1:0] dvs_mag;
    logic [XLEN-1:0] special_result;

    // Only 100 and 110 are signed. Any code outside 1xx falls through to plain DIVU.
    assign op_signed = (bus.func3 == 3'b100) || (bus.func3 == 3'b110);
    assign op_rem    = (bus.func3 == 3'b110) || (bus.func3 == 3'b111);
    assign div_zero  = (bus.divisor == '0);
    assign overflow  = op_signed && (bus.dividend == 32'h8000_0000) && (bus.divisor == '1);
    assign special   = div_zero || overflow;
    assign dvd_mag   = (op_signed && bus.dividend[XLEN-1]) ? -bus.dividend : bus.dividend;
    assign dvs_mag   = (op_signed && bus.divisor[XLEN-1])  ? -bus.divisor  : bus.divisor;
    assign special_result = div_zero ? (op_rem ? bus.dividend : '1)
                                     : (op_rem ? '0 : 32'h8000_0000);

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] new_rem;
    logic [XLEN-1:0] new_quo;
    logic [XLEN-1:0] picked;
    logic [XLEN-1:0] fixed;

    // A 33-bit trial subtract. The sign bit of the difference decides whether to restore.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, div_mag_q};
    assign new_rem = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign new_quo = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign picked  = is_rem_q ? new_rem : new_quo;
    assign fixed   = negate_q ? -picked : picked;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    accept     = 1'b1;
                    state_next = special ? FIN : CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (count_q == 6'd31) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A flush in CALC freezes the datapath, so result keeps the last completed value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_rem_q  <= 1'b0;
            negate_q  <= 1'b0;
            count_q   <= '0;
            div_mag_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_rem_q  <= op_rem;
                        negate_q  <= op_rem ? (op_signed && bus.dividend[XLEN-1])
                                            : (op_signed && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]));
                        count_q   <= '0;
                        div_mag_q <= dvs_mag;
                        rem_q     <= '0;
                        quo_q     <= dvd_mag;
                        if (special) begin
                            result_q <= special_result;
                        end
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        rem_q   <= new_rem;
                        quo_q   <= new_quo;
                        count_q <= count_q + 6'd1;
                        if (count_q == 6'd31) begin
                            result_q <= fixed;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == FIN);
    assign bus.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit. Expected values come from plain integer division
// with the RISC-V corner-case rules, not from the RTL algorithm.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst;

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic model_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = (f == 3'b100) || (f == 3'b110);
        return (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic   sgn;
        logic   rem;
        longint sa;
        longint sb;
        longint q;
        longint r;
        sgn = (f == 3'b100) || (f == 3'b110);
        rem = (f == 3'b110) || (f == 3'b111);
        if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return rem ? r[31:0] : q[31:0];
    endfunction

    // Issues one request from a negedge and returns at the negedge of the done cycle.
    // Cycle 1 is the cycle after the accepting edge. A latency of 0 means done never came.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output int busy_cycles);
        bus.func3    = f;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        res = 32'h0;
        busy_cycles = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                lat = cyc;
                res = bus.result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.func3 = 3'b101;
        bus.dividend = 32'h0;
        bus.divisor = 32'h0;
        #12;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b result=%h expected 0 0 00000000", bus.busy, bus.done, bus.result);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int lat, bc;
        logic [31:0] res;
        run_op(3'b101, 32'd100, 32'd7, lat, res, bc);
        checks++;
        if (lat !== 33 || res !== 32'h0000_000E || bc !== 33) begin
            errors++;
            $display("[TB] FAIL divu_100_7: got lat=%0d res=%h busy=%0d expected 33 0000000e 33", lat, res, bc);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL divu_done_pulse: got done=%b busy=%b expected 0 0", bus.done, bus.busy);
        end
        run_op(3'b111, 32'd100, 32'd7, lat, res, bc);
        checks++;
        if (lat !== 33 || res !== 32'h0000_0002) begin
            errors++;
            $display("[TB] FAIL remu_100_7: got lat=%0d res=%h expected 33 00000002", lat, res);
        end
        @(negedge clk);
    endtask

    task automatic test_signed();
        int lat, bc;
        logic [31:0] res;
        logic [2:0]  f_tab [3] = '{3'b100, 3'b110, 3'b100};
        logic [31:0] a_tab [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
        logic [31:0] b_tab [3] = '{32'd2, 32'd2, 32'hFFFF_FFFE};
        logic [31:0] e_tab [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        for (int i = 0; i < 3; i++) begin
            run_op(f_tab[i], a_tab[i], b_tab[i], lat, res, bc);
            checks++;
            if (lat !== 33 || res !== e_tab[i]) begin
                errors++;
                $display("[TB] FAIL signed_%0d: got lat=%0d res=%h expected 33 %h", i, lat, res, e_tab[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_special();
        int lat, bc;
        logic [31:0] res;
        logic [2:0]  f_tab [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] a_tab [4] = '{32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b_tab [4] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] e_tab [4] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            run_op(f_tab[i], a_tab[i], b_tab[i], lat, res, bc);
            checks++;
            if (lat !== 1 || res !== e_tab[i] || bc !== 1) begin
                errors++;
                $display("[TB] FAIL special_%0d: got lat=%0d res=%h busy=%0d expected 1 %h 1", i, lat, res, bc, e_tab[i]);
            end
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL special_idle_%0d: got busy=%b done=%b expected 0 0", i, bus.busy, bus.done);
            end
        end
    endtask

    task automatic test_flush();
        int lat, bc, seen_done;
        logic [31:0] res;
        run_op(3'b101, 32'd100, 32'd7, lat, res, bc);
        @(negedge clk);
        bus.func3 = 3'b101;
        bus.dividend = 32'd1000;
        bus.divisor = 32'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        seen_done = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || seen_done !== 0 || bus.result !== 32'h0000_000E) begin
            errors++;
            $display("[TB] FAIL flush_abort: got busy=%b done=%b early_done=%0d result=%h expected 0 0 0 0000000e",
                     bus.busy, bus.done, seen_done, bus.result);
        end
        run_op(3'b101, 32'd1000, 32'd3, lat, res, bc);
        checks++;
        if (lat !== 33 || res !== 32'h0000_014D) begin
            errors++;
            $display("[TB] FAIL flush_restart: got lat=%0d res=%h expected 33 0000014d", lat, res);
        end
        @(negedge clk);
        bus.func3 = 3'b101;
        bus.dividend = 32'd50;
        bus.divisor = 32'd0;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        seen_done = 0;
        bc = 0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            if (bus.done) seen_done++;
            if (bus.busy) bc++;
        end
        checks++;
        if (bc !== 0 || seen_done !== 0 || bus.result !== 32'h0000_014D) begin
            errors++;
            $display("[TB] FAIL start_flush_collision: got busy_cycles=%0d dones=%0d result=%h expected 0 0 0000014d",
                     bc, seen_done, bus.result);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [31:0] res;
        run_op(3'b101, 32'h0000_0009, 32'h0, lat, res, bc);
        checks++;
        if (lat !== 1 || res !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL b2b_first: got lat=%0d res=%h expected 1 ffffffff", lat, res);
        end
        @(negedge clk);
        run_op(3'b100, 32'hFFFF_FF9C, 32'd9, lat, res, bc);
        checks++;
        if (lat !== 33 || res !== model_result(3'b100, 32'hFFFF_FF9C, 32'd9)) begin
            errors++;
            $display("[TB] FAIL b2b_second: got lat=%0d res=%h expected 33 %h", lat, res, model_result(3'b100, 32'hFFFF_FF9C, 32'd9));
        end
        @(negedge clk);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, bc);
        checks++;
        if (lat !== 1 || res !== 32'h0) begin
            errors++;
            $display("[TB] FAIL b2b_third: got lat=%0d res=%h expected 1 00000000", lat, res);
        end
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        int first_cyc, second_cyc, ndone;
        logic [31:0] res1, res2;
        logic busy34;
        first_cyc = 0;
        second_cyc = 0;
        ndone = 0;
        res1 = 32'h0;
        res2 = 32'h0;
        busy34 = 1'b1;
        bus.func3 = 3'b101;
        bus.dividend = 32'd100;
        bus.divisor = 32'd7;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.dividend = 32'd1000;
        bus.divisor = 32'd3;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            if (cyc == 34) busy34 = bus.busy;
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    first_cyc = cyc;
                    res1 = bus.result;
                end else begin
                    second_cyc = cyc;
                    res2 = bus.result;
                    bus.start = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (first_cyc !== 33 || res1 !== 32'h0000_000E || busy34 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_start_first: got cyc=%0d res=%h busy34=%b expected 33 0000000e 0", first_cyc, res1, busy34);
        end
        checks++;
        if (second_cyc !== 67 || res2 !== 32'h0000_014D) begin
            errors++;
            $display("[TB] FAIL held_start_second: got cyc=%0d res=%h expected 67 0000014d", second_cyc, res2);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int dones, bc;
        bus.func3 = 3'b101;
        bus.dividend = 32'hDEAD_BEEF;
        bus.divisor = 32'd5;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got busy=%b done=%b result=%h expected 0 0 00000000", bus.busy, bus.done, bus.result);
        end
        #1 rst = 1'b1;
        dones = 0;
        bc = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.busy) bc++;
        end
        checks++;
        if (dones !== 0 || bc !== 0 || bus.result !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_abort: got dones=%0d busy_cycles=%0d result=%h expected 0 0 00000000", dones, bc, bus.result);
        end
    endtask

    task automatic test_random();
        int lat, bc, exp_lat;
        logic [31:0] res, a, b, exp_res;
        logic [2:0]  f;
        int sel;
        for (int i = 0; i < 24; i++) begin
            f = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            a = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'h0;
            else if (sel == 1) begin
                b = 32'hFFFF_FFFF;
                a = 32'h8000_0000;
            end
            else if (sel <= 4) b = 32'($urandom_range(1, 20));
            else b = $urandom;
            exp_res = model_result(f, a, b);
            exp_lat = model_special(f, a, b) ? 1 : 33;
            run_op(f, a, b, lat, res, bc);
            checks++;
            if (lat !== exp_lat || res !== exp_res || bc !== exp_lat) begin
                errors++;
                $display("[TB] FAIL random_%0d f=%b a=%h b=%h: got lat=%0d res=%h busy=%0d expected %0d %h %0d",
                         i, f, a, b, lat, res, bc, exp_lat, exp_res, exp_lat);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_flush();
        test_back_to_back();
        test_ignored_start();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
